// File: rtl/cor_pkg.sv
// rtl/cor_pkg.sv - shared correlator index field positions and default widths
package cor_pkg;

    // cor_index field layout
    localparam int COR_IDX_W       = 5;
    localparam int COR_IDX_NEW_BIT = 0;
    localparam int COR_IDX_OVW_BIT = 1;
    localparam int COR_IDX_NUM_MSB = 4;
    localparam int COR_IDX_NUM_LSB = 2;

    // Default datapath widths
    localparam int DEF_IN_W   = 16;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_ADDR_W = 10;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - signed add with saturation to W bits and an overflow flag
//
// Ports:
//   a, b : W-bit two's-complement operands
//   sum  : a + b clamped to [-2^(W-1), 2^(W-1)-1]
//   ovf  : high when the clamp was applied
module sat_add #(
    parameter int W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    assign full = {a[W-1], a} + {b[W-1], b};

    // The W+1 bit result overflowed W bits exactly when its top two bits differ;
    // the top bit then gives the true sign and thus which rail to clamp to.
    always_comb begin
        sum = full[W-1:0];
        ovf = 1'b0;
        if (full[W] != full[W-1]) begin
            ovf = 1'b1;
            sum = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/coherent_sum_writer.sv
// rtl/coherent_sum_writer.sv - pipelined coherent-sum accumulate into buffer RAM
//
// Ports:
//   clk, rst_b              clock, asynchronous active-low reset
//   coherent_sum_valid      one-cycle strobe with cor_index / i / q sums
//   cor_index               {correlator[2:0], overwrite_protect, new_sum}
//   i/q_coherent_sum        signed IN_W dump values
//   buffer_base             channel base address in the coherent buffer
//   flush                   drops every in-flight entry and a same-cycle strobe
//   clear_status            clears both sticky bits (wins over a same-cycle set)
//   ram_rd_*                read port; data returns the cycle after ram_rd_en
//   ram_wr_*                write port, {I,Q} packed
//   write_done              pulse coincident with ram_wr_en
//   overwrite_sticky        a write carried the overwrite-protect flag
//   saturate_sticky         an accumulate saturated on I or Q
//   busy                    any pipeline stage holds a live entry
//
// Pipeline: strobe N -> S1 (read) N+1 -> S2 (add) N+2 -> S3 (write) N+3.
module coherent_sum_writer
    import cor_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 coherent_sum_valid,
    input  logic [COR_IDX_W-1:0] cor_index,
    input  logic [IN_W-1:0]      i_coherent_sum,
    input  logic [IN_W-1:0]      q_coherent_sum,
    input  logic [ADDR_W-1:0]    buffer_base,
    input  logic                 flush,
    input  logic                 clear_status,
    output logic                 ram_rd_en,
    output logic [ADDR_W-1:0]    ram_rd_addr,
    input  logic [2*ACC_W-1:0]   ram_rd_data,
    output logic                 ram_wr_en,
    output logic [ADDR_W-1:0]    ram_wr_addr,
    output logic [2*ACC_W-1:0]   ram_wr_data,
    output logic                 write_done,
    output logic                 overwrite_sticky,
    output logic                 saturate_sticky,
    output logic                 busy
);

    logic [ADDR_W-1:0] addr_in;
    logic [ACC_W-1:0]  i_ext;
    logic [ACC_W-1:0]  q_ext;
    logic              accept;

    // S1
    logic              v1;
    logic [ADDR_W-1:0] addr1;
    logic              new1;
    logic              ovw1;
    logic [ACC_W-1:0]  i1;
    logic [ACC_W-1:0]  q1;

    // S2
    logic              v2;
    logic [ADDR_W-1:0] addr2;
    logic              new2;
    logic              ovw2;
    logic [ACC_W-1:0]  i2;
    logic [ACC_W-1:0]  q2;

    // Last completed write, kept one extra cycle for forwarding
    logic              v4;
    logic [ADDR_W-1:0] addr4;
    logic [2*ACC_W-1:0] data4;

    logic [2*ACC_W-1:0] stored;
    logic [ACC_W-1:0]  sum_i;
    logic [ACC_W-1:0]  sum_q;
    logic              ovf_i;
    logic              ovf_q;
    logic [ACC_W-1:0]  next_i;
    logic [ACC_W-1:0]  next_q;
    logic              sat_hit;
    logic              load_s3;

    assign addr_in = buffer_base + ADDR_W'(cor_index[COR_IDX_NUM_MSB:COR_IDX_NUM_LSB]);
    assign i_ext   = ACC_W'($signed(i_coherent_sum));
    assign q_ext   = ACC_W'($signed(q_coherent_sum));
    assign accept  = coherent_sum_valid & ~flush;

    // Two hazards reach S2 with stale RAM data: the entry one ahead is being
    // written right now (S3), and the entry two ahead was written in the same
    // cycle S2's read was issued, which the RAM returns as old data. The
    // younger write (S3) has priority.
    always_comb begin
        stored = ram_rd_data;
        if (v4 && (addr4 == addr2)) begin
            stored = data4;
        end
        if (ram_wr_en && (ram_wr_addr == addr2)) begin
            stored = ram_wr_data;
        end
    end

    sat_add #(.W(ACC_W)) u_sat_i (
        .a   (stored[2*ACC_W-1:ACC_W]),
        .b   (i2),
        .sum (sum_i),
        .ovf (ovf_i)
    );

    sat_add #(.W(ACC_W)) u_sat_q (
        .a   (stored[ACC_W-1:0]),
        .b   (q2),
        .sum (sum_q),
        .ovf (ovf_q)
    );

    assign next_i  = new2 ? i2 : sum_i;
    assign next_q  = new2 ? q2 : sum_q;
    assign load_s3 = v2 & ~flush;
    assign sat_hit = load_s3 & ~new2 & (ovf_i | ovf_q);
    assign busy    = v1 | v2 | ram_wr_en;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            v1               <= 1'b0;
            addr1            <= '0;
            new1             <= 1'b0;
            ovw1             <= 1'b0;
            i1               <= '0;
            q1               <= '0;
            v2               <= 1'b0;
            addr2            <= '0;
            new2             <= 1'b0;
            ovw2             <= 1'b0;
            i2               <= '0;
            q2               <= '0;
            v4               <= 1'b0;
            addr4            <= '0;
            data4            <= '0;
            ram_rd_en        <= 1'b0;
            ram_rd_addr      <= '0;
            ram_wr_en        <= 1'b0;
            ram_wr_addr      <= '0;
            ram_wr_data      <= '0;
            write_done       <= 1'b0;
            overwrite_sticky <= 1'b0;
            saturate_sticky  <= 1'b0;
        end else begin
            // S1 capture and read issue
            v1        <= accept;
            ram_rd_en <= accept & ~cor_index[COR_IDX_NEW_BIT];
            if (accept) begin
                addr1 <= addr_in;
                new1  <= cor_index[COR_IDX_NEW_BIT];
                ovw1  <= cor_index[COR_IDX_OVW_BIT];
                i1    <= i_ext;
                q1    <= q_ext;
                if (!cor_index[COR_IDX_NEW_BIT]) begin
                    ram_rd_addr <= addr_in;
                end
            end

            // S1 -> S2
            v2 <= v1 & ~flush;
            if (v1) begin
                addr2 <= addr1;
                new2  <= new1;
                ovw2  <= ovw1;
                i2    <= i1;
                q2    <= q1;
            end

            // S2 -> S3 (write)
            ram_wr_en  <= load_s3;
            write_done <= load_s3;
            if (load_s3) begin
                ram_wr_addr <= addr2;
                ram_wr_data <= {next_i, next_q};
            end

            v4    <= ram_wr_en;
            addr4 <= ram_wr_addr;
            data4 <= ram_wr_data;

            // Stickies rise together with the write that caused them
            if (clear_status) begin
                overwrite_sticky <= 1'b0;
                saturate_sticky  <= 1'b0;
            end else begin
                overwrite_sticky <= overwrite_sticky | (load_s3 & ovw2);
                saturate_sticky  <= saturate_sticky | sat_hit;
            end
        end
    end

endmodule
